// File: rtl/p4_router_egress_port_adapt.sv
// Egress port adaptation: frame-boundary port gate, converged-bus to port-width downconverter,
// and saturating per-port frame/byte/drop counters.
module p4_router_egress_port_adapt #(
    parameter int IN_DATA_BYTES  = 64,
    parameter int OUT_DATA_BYTES = 8,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [IN_DATA_BYTES*8-1:0]  s_axis_tdata,
    input  logic [IN_DATA_BYTES-1:0]    s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [OUT_DATA_BYTES*8-1:0] m_axis_tdata,
    output logic [OUT_DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                        m_axis_tlast,
    input  logic                        enable,
    input  logic                        cnt_clear,
    output logic                        connected,
    output logic [COUNTER_WIDTH-1:0]    frame_cnt,
    output logic [COUNTER_WIDTH-1:0]    byte_cnt,
    output logic [COUNTER_WIDTH-1:0]    drop_cnt
);

    localparam int R     = IN_DATA_BYTES / OUT_DATA_BYTES;
    localparam int SEG_W = (R > 1) ? $clog2(R) : 1;
    localparam int OW    = OUT_DATA_BYTES * 8;

    generate
        if ((IN_DATA_BYTES % OUT_DATA_BYTES) != 0 || IN_DATA_BYTES < OUT_DATA_BYTES) begin : g_bad_ratio
            $error("IN_DATA_BYTES must be a nonzero multiple of OUT_DATA_BYTES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PASS, DROP} gate_t;

    gate_t                      state, state_nxt;
    logic [IN_DATA_BYTES*8-1:0] buf_data_p1;
    logic [IN_DATA_BYTES-1:0]   buf_keep_p1;
    logic                       buf_last_p1;
    logic                       vld_p1;
    logic [SEG_W-1:0]           seg_idx_p1;
    logic [SEG_W-1:0]           seg_last_p1;
    logic                       seg_final, m_hs, final_hs, s_accept, load;

    // Index of the highest segment carrying any enabled byte (0 when keep is empty).
    function automatic logic [SEG_W-1:0] top_seg(input logic [IN_DATA_BYTES-1:0] keep);
        logic [SEG_W-1:0] t;
        t = '0;
        for (int i = 0; i < R; i++)
            if (|keep[i*OUT_DATA_BYTES +: OUT_DATA_BYTES]) t = SEG_W'(i);
        return t;
    endfunction

    function automatic logic [COUNTER_WIDTH-1:0] sat_add(input logic [COUNTER_WIDTH-1:0] a,
                                                         input logic [COUNTER_WIDTH-1:0] b);
        logic [COUNTER_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNTER_WIDTH] ? {COUNTER_WIDTH{1'b1}} : s[COUNTER_WIDTH-1:0];
    endfunction

    assign seg_final     = (seg_idx_p1 == seg_last_p1);
    assign m_hs          = vld_p1 && m_axis_tready;
    assign final_hs      = m_hs && seg_final;
    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = buf_data_p1[seg_idx_p1*OW +: OW];
    assign m_axis_tkeep  = buf_keep_p1[seg_idx_p1*OUT_DATA_BYTES +: OUT_DATA_BYTES];
    assign m_axis_tlast  = buf_last_p1 && seg_final;
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    // Empty non-final beats carry nothing to emit and are simply consumed.
    assign load          = s_accept && (state == PASS) && ((|s_axis_tkeep) || s_axis_tlast);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: if (s_axis_tvalid) state_nxt = enable ? PASS : DROP;
            PASS: begin
                s_axis_tready = !vld_p1 || final_hs;
                if (s_axis_tvalid && s_axis_tready && s_axis_tlast) state_nxt = IDLE;
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate sampling: enable is only observed between frames.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)           connected <= 1'b0;
        else if (state == IDLE) connected <= enable;
    end

    // Stage p1: one-word segment buffer feeding the port.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            buf_data_p1 <= '0;
            buf_keep_p1 <= '0;
            buf_last_p1 <= 1'b0;
            vld_p1      <= 1'b0;
            seg_idx_p1  <= '0;
            seg_last_p1 <= '0;
        end else if (load) begin
            buf_data_p1 <= s_axis_tdata;
            buf_keep_p1 <= s_axis_tkeep;
            buf_last_p1 <= s_axis_tlast;
            vld_p1      <= 1'b1;
            seg_idx_p1  <= '0;
            seg_last_p1 <= top_seg(s_axis_tkeep);
        end else if (final_hs) begin
            vld_p1 <= 1'b0;
        end else if (m_hs) begin
            seg_idx_p1 <= seg_idx_p1 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (cnt_clear) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (m_hs && m_axis_tlast)
                frame_cnt <= sat_add(frame_cnt, COUNTER_WIDTH'(1));
            if (m_hs)
                byte_cnt <= sat_add(byte_cnt, COUNTER_WIDTH'($countones(m_axis_tkeep)));
            if (state == DROP && s_accept && s_axis_tlast)
                drop_cnt <= sat_add(drop_cnt, COUNTER_WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_p4_router_egress_port_adapt.sv
// Bench for p4_router_egress_port_adapt: scoreboarded 64B->8B stream, gate, counters, reset.
module tb_p4_router_egress_port_adapt;

    localparam int IN  = 64;
    localparam int OUT = 8;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [IN*8-1:0] s_axis_tdata = '0;
    logic [IN-1:0]  s_axis_tkeep = '0;
    logic           s_axis_tlast = 1'b0;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic [OUT*8-1:0] m_axis_tdata;
    logic [OUT-1:0] m_axis_tkeep;
    logic           m_axis_tlast;
    logic           enable = 1'b1;
    logic           cnt_clear = 1'b0;
    logic           connected;
    logic [31:0]    frame_cnt, byte_cnt, drop_cnt;

    logic           d4_s_tready, d4_m_tvalid, d4_m_tlast, d4_connected;
    logic [OUT*8-1:0] d4_m_tdata;
    logic [OUT-1:0] d4_m_tkeep;
    logic [3:0]     d4_frame_cnt, d4_byte_cnt, d4_drop_cnt;

    p4_router_egress_port_adapt #(.IN_DATA_BYTES(IN), .OUT_DATA_BYTES(OUT), .COUNTER_WIDTH(32)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .enable(enable), .cnt_clear(cnt_clear), .connected(connected),
        .frame_cnt(frame_cnt), .byte_cnt(byte_cnt), .drop_cnt(drop_cnt));

    p4_router_egress_port_adapt #(.IN_DATA_BYTES(IN), .OUT_DATA_BYTES(OUT), .COUNTER_WIDTH(4)) dut4 (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(d4_s_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(d4_m_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(d4_m_tdata),
        .m_axis_tkeep(d4_m_tkeep), .m_axis_tlast(d4_m_tlast),
        .enable(enable), .cnt_clear(cnt_clear), .connected(d4_connected),
        .frame_cnt(d4_frame_cnt), .byte_cnt(d4_byte_cnt), .drop_cnt(d4_drop_cnt));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } seg_t;

    typedef struct {
        logic [63:0] keep;
        int          beats;
        logic [7:0]  last_keep;
        int          bytes;
    } vec_t;

    seg_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_bytes = 0;
    int          exp_frames = 0;
    int          mon_beats = 0;
    logic [7:0]  mon_last_keep = '0;
    bit          rdy_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IN*8-1:0] rnd512();
        logic [IN*8-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] keep_n(input int n);
        logic [63:0] one;
        one = 64'd1;
        return (n >= 64) ? '1 : ((one << n) - 64'd1);
    endfunction

    // Reference segmentation of one accepted converged-bus beat.
    task automatic push_expected(input logic [IN*8-1:0] d, input logic [IN-1:0] k, input logic l);
        int   hs;
        seg_t s;
        hs = -1;
        for (int i = 0; i < IN/OUT; i++) if (k[i*OUT +: OUT] != '0) hs = i;
        if (hs < 0) begin
            if (l) begin
                s.d = d[63:0]; s.k = '0; s.l = 1'b1;
                sb.push_back(s);
                exp_frames++;
            end
        end else begin
            for (int i = 0; i <= hs; i++) begin
                s.d = d[i*64 +: 64];
                s.k = k[i*OUT +: OUT];
                s.l = l && (i == hs);
                sb.push_back(s);
                exp_bytes += $countones(s.k);
                if (s.l) exp_frames++;
            end
        end
    endtask

    task automatic send_beat(input logic [IN*8-1:0] d, input logic [IN-1:0] k, input logic l,
                             input bit pass, output int waits);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
        waits = 0;
        @(negedge clk);
        while (!s_axis_tready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            checks++; errors++;
            $display("FAIL s_accept_timeout: s_tready got 0, expected 1 within 200 cycles");
        end else if (pass) begin
            push_expected(d, k, l);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || m_axis_tvalid) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d segments still pending, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        m_axis_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard pop plus hold-while-stalled check.
    logic        stall_prev = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;
    logic        prev_l;
    always @(negedge clk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'(m_axis_tvalid && m_axis_tdata == prev_d &&
                                        m_axis_tkeep == prev_k && m_axis_tlast == prev_l), 64'd1);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got keep 0x%0h last %0d, expected no beat",
                             m_axis_tkeep, m_axis_tlast);
                end else begin
                    seg_t        e;
                    logic [63:0] mask;
                    e = sb.pop_front();
                    for (int i = 0; i < OUT; i++) mask[i*8 +: 8] = e.k[i] ? 8'hFF : 8'h00;
                    check("m_tkeep", 64'(m_axis_tkeep), 64'(e.k));
                    check("m_tlast", 64'(m_axis_tlast), 64'(e.l));
                    check("m_tdata", m_axis_tdata & mask, e.d & mask);
                end
                mon_beats++;
                if (m_axis_tlast) mon_last_keep = m_axis_tkeep;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata; prev_k = m_axis_tkeep; prev_l = m_axis_tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   w, mb, fb, bb, fr0, by0, eb0, ef0, nb, n;
        logic [63:0] k;

        tbl[0] = '{keep: '1,             beats: 8, last_keep: 8'hFF, bytes: 64};
        tbl[1] = '{keep: 64'h1,          beats: 1, last_keep: 8'h01, bytes: 1};
        tbl[2] = '{keep: 64'h0,          beats: 1, last_keep: 8'h00, bytes: 0};
        tbl[3] = '{keep: 64'h1FF,        beats: 2, last_keep: 8'h01, bytes: 9};
        tbl[4] = '{keep: 64'hFF_FFFFFFFF, beats: 5, last_keep: 8'hFF, bytes: 40};
        tbl[5] = '{keep: 64'h7FFFFFFF_FFFFFFFF, beats: 8, last_keep: 8'h7F, bytes: 63};

        // Reset state
        #23;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", m_axis_tdata, 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_connected", 64'(connected), 64'd0);
        check("rst_counters", 64'(frame_cnt | byte_cnt | drop_cnt), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("connected_enabled", 64'(connected), 64'd1);

        // 100-byte frame
        mb = mon_beats;
        send_beat(rnd512(), '1, 1'b0, 1'b1, w);
        send_beat(rnd512(), keep_n(36), 1'b1, 1'b1, w);
        drain();
        check("t1_beats", 64'(mon_beats - mb), 64'd13);
        check("t1_last_keep", 64'(mon_last_keep), 64'h0F);
        check("t1_byte_cnt", 64'(byte_cnt), 64'd100);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

        // Single-beat frame vectors
        for (int t = 0; t < 6; t++) begin
            mb = mon_beats; fb = frame_cnt; bb = byte_cnt;
            send_beat(rnd512(), tbl[t].keep, 1'b1, 1'b1, w);
            drain();
            check($sformatf("tbl%0d_beats", t), 64'(mon_beats - mb), 64'(tbl[t].beats));
            check($sformatf("tbl%0d_last_keep", t), 64'(mon_last_keep), 64'(tbl[t].last_keep));
            check($sformatf("tbl%0d_bytes", t), 64'(byte_cnt - bb), 64'(tbl[t].bytes));
            check($sformatf("tbl%0d_frames", t), 64'(frame_cnt - fb), 64'd1);
        end

        // Disabled port drops a frame
        enable = 1'b0;
        repeat (2) @(posedge clk); #1;
        mb = mon_beats;
        send_beat(rnd512(), '1, 1'b0, 1'b0, w);
        check("t2_connected", 64'(connected), 64'd0);
        send_beat(rnd512(), '1, 1'b0, 1'b0, w);
        check("t2_beat2_waits", 64'(w), 64'd0);
        send_beat(rnd512(), keep_n(20), 1'b1, 1'b0, w);
        check("t2_beat3_waits", 64'(w), 64'd0);
        drain();
        check("t2_m_beats", 64'(mon_beats - mb), 64'd0);
        check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t2_connected_after", 64'(connected), 64'd0);

        // Mid-frame disable takes effect at the next frame
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        mb = mon_beats;
        send_beat(rnd512(), '1, 1'b0, 1'b1, w);
        send_beat(rnd512(), '1, 1'b0, 1'b1, w);
        enable = 1'b0;
        send_beat(rnd512(), '1, 1'b0, 1'b1, w);
        check("t3_connected_mid", 64'(connected), 64'd1);
        send_beat(rnd512(), '1, 1'b1, 1'b1, w);
        drain();
        check("t3_m_beats", 64'(mon_beats - mb), 64'd32);
        check("t3_connected_after", 64'(connected), 64'd0);
        mb = mon_beats;
        send_beat(rnd512(), '1, 1'b1, 1'b0, w);
        drain();
        check("t3_next_dropped", 64'(mon_beats - mb), 64'd0);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd2);

        // Random frames under random backpressure
        enable = 1'b1;
        rdy_mode = 1'b1;
        repeat (2) @(posedge clk); #1;
        fr0 = frame_cnt; by0 = byte_cnt; eb0 = exp_bytes; ef0 = exp_frames;
        for (int f = 0; f < 20; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if (b == nb - 1) begin
                    n = $urandom_range(0, 64);
                    k = keep_n(n);
                end else begin
                    k = ($urandom_range(0, 7) == 0) ? 64'd0 : '1;
                end
                send_beat(rnd512(), k, 1'(b == nb - 1), 1'b1, w);
            end
        end
        drain();
        check("t4_byte_cnt", 64'(byte_cnt - by0), 64'(exp_bytes - eb0));
        check("t4_frame_cnt", 64'(frame_cnt - fr0), 64'(exp_frames - ef0));

        // Counter clear coincident with the tlast handshake
        rdy_mode = 1'b0;
        repeat (2) @(posedge clk); #1;
        send_beat(rnd512(), 64'hFF, 1'b1, 1'b1, w);
        n = 0;
        @(negedge clk);
        while (!(m_axis_tvalid && m_axis_tlast && m_axis_tready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_tlast_seen", 64'(m_axis_tvalid && m_axis_tlast), 64'd1);
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        drain();
        check("t5_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t5_byte_cnt", 64'(byte_cnt), 64'd0);
        check("t5_drop_cnt", 64'(drop_cnt), 64'd0);

        // Saturation with a 4-bit counter instance
        for (int f = 0; f < 20; f++) send_beat(rnd512(), 64'h1, 1'b1, 1'b1, w);
        drain();
        check("t6_frame_cnt32", 64'(frame_cnt), 64'd20);
        check("t6_byte_cnt32", 64'(byte_cnt), 64'd20);
        check("t6_frame_cnt4", 64'(d4_frame_cnt), 64'd15);
        check("t6_byte_cnt4", 64'(d4_byte_cnt), 64'd15);

        // Reset pulse mid-frame
        send_beat(rnd512(), '1, 1'b0, 1'b1, w);
        aresetn = 1'b0;
        #1;
        check("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("t6_rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("t6_rst_m_tdata", m_axis_tdata, 64'd0);
        check("t6_rst_connected", 64'(connected), 64'd0);
        check("t6_rst_counters", 64'(frame_cnt | byte_cnt | drop_cnt), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (3) @(posedge clk); #1;
        mb = mon_beats;
        send_beat(rnd512(), '1, 1'b1, 1'b1, w);
        drain();
        check("t6_clean_beats", 64'(mon_beats - mb), 64'd8);
        check("t6_clean_frame_cnt", 64'(frame_cnt), 64'd1);
        check("t6_clean_byte_cnt", 64'(byte_cnt), 64'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
